// File: rtl/jtag_master.sv
// Clock-divided JTAG initiator: shifts up to 32 TMS/TDI bits per command
// and returns the TDO bits captured at the end of each TCK high phase.
module jtag_master #(
    parameter int unsigned DIV   = 2,
    parameter int unsigned W_DIV = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_tms,
    input  logic [31:0] cmd_tdi,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_tdo,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    localparam logic [W_DIV-1:0] CNT_LAST = W_DIV'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [W_DIV-1:0] cnt;
    logic [5:0]       idx;
    logic [4:0]       len;
    logic [31:0]      tms_sh;
    logic [31:0]      tdi_sh;
    logic [31:0]      cap;
    logic [31:0]      cap_next;
    logic             cnt_done;
    logic             last_bit;

    assign cnt_done  = (cnt == CNT_LAST);
    assign last_bit  = (idx == {1'b0, len});
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Capture vector with the current TDO sample merged in at the bit index.
    always_comb begin
        cap_next = cap;
        cap_next[idx[4:0]] = tdo;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cmd_valid) state_next = LOW;
            LOW:  if (cnt_done) state_next = HIGH;
            HIGH: if (cnt_done) state_next = last_bit ? RESP : LOW;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: half-period counter, bit shifting, TDO capture and response.
    // The shift registers hold the bits still to be driven; bit 0 of the
    // command goes straight to tms/tdi at acceptance, so they load bits 31:1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            len       <= '0;
            tms_sh    <= '0;
            tdi_sh    <= '0;
            cap       <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_tdo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        len    <= cmd_len;
                        tms_sh <= {1'b0, cmd_tms[31:1]};
                        tdi_sh <= {1'b0, cmd_tdi[31:1]};
                        idx    <= '0;
                        cap    <= '0;
                        cnt    <= '0;
                        tms    <= cmd_tms[0];
                        tdi    <= cmd_tdi[0];
                    end
                end
                LOW: begin
                    if (cnt_done) begin
                        cnt <= '0;
                        tck <= 1'b1;
                    end else begin
                        cnt <= cnt + W_DIV'(1);
                    end
                end
                HIGH: begin
                    if (cnt_done) begin
                        cnt <= '0;
                        tck <= 1'b0;
                        cap <= cap_next;
                        idx <= idx + 6'd1;
                        if (last_bit) begin
                            rsp_valid <= 1'b1;
                            rsp_tdo   <= cap_next;
                        end else begin
                            tms    <= tms_sh[0];
                            tdi    <= tdi_sh[0];
                            tms_sh <= tms_sh >> 1;
                            tdi_sh <= tdi_sh >> 1;
                        end
                    end else begin
                        cnt <= cnt + W_DIV'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Randomized self-checking bench for jtag_master: two instances (DIV=2 and
// DIV=1) share stimulus; a bit-level reference model predicts the response.
module tb_jtag_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        rsp_ready;
    logic        sel;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_tms;
    logic [31:0] cmd_tdi;
    logic [1:0]  tdo_mode;
    logic        tdo;

    logic        cr0, rv0, b0, tck0, tms0, tdi0;
    logic        cr1, rv1, b1, tck1, tms1, tdi1;
    logic [31:0] rt0, rt1;

    logic        cmd_ready, rsp_valid, busy, tck, tms, tdi;
    logic [31:0] rsp_tdo;

    int n_checks = 0;
    int n_errors = 0;
    int cur_div  = 2;

    logic [4:0]  exp_len;
    logic [31:0] exp_tms;
    logic [31:0] exp_tdi;
    logic [1:0]  exp_mode;

    always #5 clk = ~clk;

    assign cmd_ready = sel ? cr1  : cr0;
    assign rsp_valid = sel ? rv1  : rv0;
    assign busy      = sel ? b1   : b0;
    assign tck       = sel ? tck1 : tck0;
    assign tms       = sel ? tms1 : tms0;
    assign tdi       = sel ? tdi1 : tdi0;
    assign rsp_tdo   = sel ? rt1  : rt0;

    // Target stand-in: loopback, stuck-at-1, or TMS xor TDI.
    assign tdo = (tdo_mode == 2'd0) ? tdi : (tdo_mode == 2'd1) ? 1'b1 : (tms ^ tdi);

    jtag_master #(.DIV(2), .W_DIV(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(cr0),
        .cmd_len(cmd_len), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
        .rsp_valid(rv0), .rsp_ready(rsp_ready & ~sel), .rsp_tdo(rt0),
        .busy(b0), .tck(tck0), .tms(tms0), .tdi(tdi0), .tdo(tdo)
    );

    jtag_master #(.DIV(1), .W_DIV(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & sel), .cmd_ready(cr1),
        .cmd_len(cmd_len), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
        .rsp_valid(rv1), .rsp_ready(rsp_ready & sel), .rsp_tdo(rt1),
        .busy(b1), .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdo)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: bit i of the response is what the target returns for bit i.
    function automatic logic [31:0] model_rsp(input logic [4:0] len, input logic [31:0] t_ms,
                                              input logic [31:0] t_di, input logic [1:0] mode);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i <= int'(len); i++) begin
            case (mode)
                2'd0:    r[i] = t_di[i];
                2'd1:    r[i] = 1'b1;
                default: r[i] = t_ms[i] ^ t_di[i];
            endcase
        end
        return r;
    endfunction

    task automatic present(input logic [4:0] len, input logic [31:0] t_ms,
                           input logic [31:0] t_di, input logic [1:0] mode);
        cmd_len   = len;
        cmd_tms   = t_ms;
        cmd_tdi   = t_di;
        tdo_mode  = mode;
        exp_len   = len;
        exp_tms   = t_ms;
        exp_tdi   = t_di;
        exp_mode  = mode;
        cmd_valid = 1'b1;
    endtask

    // Called at a negedge with cmd_valid high; returns at the first LOW cycle.
    task automatic accept();
        int w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("accept_wait", (w < 50) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Watches tck pulses up to the response and checks timing, bits and result.
    task automatic observe();
        int lo = 0, hi = 0, pulses = 0, bad = 0, cyc = 0;
        int limit = 32 * 2 * cur_div + 20;
        logic prev = 1'b0;
        forever begin
            if (tck && !prev) begin
                if (lo != cur_div) bad++;
                if (pulses < 32 && (tms !== exp_tms[pulses] || tdi !== exp_tdi[pulses])) bad++;
                pulses++;
                hi = 0;
            end else if (!tck && prev) begin
                if (hi != cur_div) bad++;
                lo = 0;
            end
            if (tck) hi++; else lo++;
            prev = tck;
            if (rsp_valid || cyc >= limit) break;
            cyc++;
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check_eq("pulses", pulses, 32'(int'(exp_len) + 1));
        check_eq("timing_bits", bad, 0);
        check_eq("latency", cyc, 32'((int'(exp_len) + 1) * 2 * cur_div));
        check_eq("rsp_tdo", rsp_tdo, model_rsp(exp_len, exp_tms, exp_tdi, exp_mode));
    endtask

    // Holds off the response, optionally presenting the next command meanwhile.
    task automatic consume(input int hold, input bit pend, input logic [4:0] nlen,
                           input logic [31:0] ntms, input logic [31:0] ntdi, input logic [1:0] nmode);
        logic [31:0] held;
        logic last_tms, last_tdi;
        int bad = 0;
        held = rsp_tdo;
        last_tms = exp_tms[exp_len];
        last_tdi = exp_tdi[exp_len];
        rsp_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (pend && k == 2) present(nlen, ntms, ntdi, nmode);
            @(negedge clk);
            if (rsp_tdo !== held || cmd_ready !== 1'b0 || tck !== 1'b0 || rsp_valid !== 1'b1) bad++;
        end
        if (hold > 0) check_eq("hold_stable", bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_drop", rsp_valid, 0);
        check_eq("idle_ready", cmd_ready, 1);
        check_eq("tms_tdi_hold", {tms, tdi}, {last_tms, last_tdi});
    endtask

    task automatic run_cmd(input logic [4:0] len, input logic [31:0] t_ms,
                           input logic [31:0] t_di, input logic [1:0] mode, input int hold);
        present(len, t_ms, t_di, mode);
        accept();
        observe();
        consume(hold, 1'b0, '0, '0, '0, 2'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; sel = 1'b0;
        cmd_len = '0; cmd_tms = '0; cmd_tdi = '0; tdo_mode = 2'd0;
        exp_len = '0; exp_tms = '0; exp_tdi = '0; exp_mode = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_eq("reset_outs", {28'd0, tck, tms, tdi, rsp_valid}, 32'h4);
            check_eq("reset_tdo", rsp_tdo, 0);
            check_eq("reset_hs", {busy, cmd_ready}, 32'h1);
        end
        sel = 1'b0;
        cur_div = 2;
        @(negedge clk);

        run_cmd(5'd4, 32'h1F, 32'h0, 2'd0, 0);
        run_cmd(5'd7, 32'h80, 32'hA5, 2'd0, 1);
        run_cmd(5'd0, 32'h0, 32'h0, 2'd1, 0);

        // Backpressure with a new command pending during the held response.
        present(5'd9, $urandom, $urandom, 2'd2);
        accept();
        observe();
        consume(10, 1'b1, 5'd12, $urandom, $urandom, 2'd0);
        check_eq("pend_valid", cmd_valid, 1);
        accept();
        check_eq("pend_busy", busy, 1);
        observe();
        consume(0, 1'b0, '0, '0, '0, 2'd0);

        for (int n = 0; n < 6; n++)
            run_cmd(5'($urandom_range(0, 31)), $urandom, $urandom,
                    2'($urandom_range(0, 2)), $urandom_range(0, 3));

        // Reset during the high phase of bit 3 of a 16-bit command.
        begin
            int pulses = 0, w = 0, after = 0;
            logic prev = 1'b0;
            present(5'd15, $urandom, $urandom, 2'd0);
            accept();
            while (w < 200) begin
                if (tck && !prev) pulses++;
                prev = tck;
                if (pulses == 4 && tck) break;
                w++;
                @(negedge clk);
            end
            check_eq("abort_reach", pulses, 4);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_eq("abort_outs", {28'd0, tck, tms, rsp_valid, cmd_ready}, 32'h5);
            prev = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (rsp_valid || (tck && !prev)) after++;
                prev = tck;
            end
            check_eq("abort_no_rsp", after, 0);
        end

        sel = 1'b0;
        @(negedge clk);
        sel = 1'b1;
        cur_div = 1;
        @(negedge clk);
        run_cmd(5'd31, $urandom, 32'hDEADBEEF, 2'd0, 2);
        for (int n = 0; n < 4; n++)
            run_cmd(5'($urandom_range(0, 31)), $urandom, $urandom,
                    2'($urandom_range(0, 2)), $urandom_range(0, 3));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
